gate_tt_checker: RTL and testbench
==================================

GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

Interface
REQ-001 SETTLE_CYCLES, default 4, SHALL set the cycles each input vector is held before Gate_Output is sampled; legal range 1..255.
REQ-002 GATE_OP, default 0, SHALL select the expected function: 0 AND, 1 OR, 2 XOR, 3 NAND.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Start  input  1  SHALL request one truth-table run; sampled only in IDLE.
REQ-006 Gate_Output  input  1  SHALL carry the output of the gate under test.
REQ-007 Input_A  output  1  SHALL drive gate input A from a register.
REQ-008 Input_B  output  1  SHALL drive gate input B from a register.
REQ-009 Busy  output  1  SHALL be high while in SETTLE or SAMPLE.
REQ-010 Done  output  1  SHALL pulse high for exactly one cycle at the end of a run.
REQ-011 Pass  output  1  SHALL be high when the last completed run had zero mismatches.
REQ-012 Error_Count  output  3  SHALL hold the mismatch count of the last run (0..4).
REQ-013 Fail_Vector  output  4  SHALL hold one bit per vector index, set if that vector mismatched.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE; only these four.
REQ-015 IDLE: Start=1 SHALL move to SETTLE, set vector index 0, clear Error_Count, Fail_Vector and Pass, load the settle counter.
REQ-016 Vector order SHALL be index 0:{A,B}=00, 1:10, 2:01, 3:11; Input_A/Input_B SHALL take the vector on the same edge the index changes.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then move to SAMPLE.
REQ-018 SAMPLE (one cycle) SHALL compare Gate_Output to the expected value of GATE_OP for the current vector; mismatch increments Error_Count and sets Fail_Vector[index].
REQ-019 SAMPLE with index<3 SHALL advance the index, reload the counter and return to SETTLE; index==3 SHALL go to DONE.
REQ-020 DONE SHALL assert Done and Pass=(final Error_Count==0) for one cycle, drive Input_A=Input_B=0, then return to IDLE.
REQ-021 Done SHALL assert 4*(SETTLE_CYCLES+1)+1 edges after the edge that accepted Start (21 for default).
REQ-022 Start while Busy or in DONE SHALL be ignored; Start held high SHALL start a new run on the first IDLE cycle after DONE.
REQ-023 Pass, Error_Count and Fail_Vector SHALL hold their values from DONE until the next accepted Start.
REQ-024 In IDLE, Input_A and Input_B SHALL be 0.

Reset
REQ-025 Reset_n low SHALL immediately force IDLE, index 0, Input_A=Input_B=Busy=Done=Pass=0, Error_Count=0, Fail_Vector=0000, regardless of state.
REQ-026 After Reset_n deasserts the block SHALL remain in IDLE until Start is sampled high.

Configuration
REQ-027 With GATE_TT_ABORT_EN defined, an input port Abort (1 bit) SHALL exist; Abort=1 in SETTLE or SAMPLE SHALL return to IDLE on the next edge with no Done pulse and results cleared to 0.
REQ-028 Without GATE_TT_ABORT_EN the Abort port SHALL not exist and a run always completes unless reset.

Structure
REQ-029 Package gate_tt_pkg SHALL hold the FSM state type, the GATE_OP codes and the 4-entry vector table constant.
REQ-030 The expected-value function SHALL be a combinational sub-module gate_ref (inputs A, B, op; output expected).

Verification
REQ-031 GATE_OP=0, correct AND DUT, SETTLE_CYCLES=4, one-cycle Start -> A/B = 00,10,01,11 each 5 cycles; Done at edge 21; Pass=1, Error_Count=0, Fail_Vector=0000.
REQ-032 GATE_OP=0, Gate_Output tied 1 -> Error_Count=3, Fail_Vector=0111, Pass=0, values held until next Start.
REQ-033 Start held high for 50 cycles -> runs back-to-back separated by one IDLE cycle; results cleared at each accept.
REQ-034 Reset_n low during SETTLE of index 2 -> all outputs 0 immediately; after release no activity until Start.
REQ-035 GATE_TT_ABORT_EN defined, Abort pulse during index 1 -> IDLE next edge, Done never asserts, Error_Count=0.
REQ-036 GATE_OP=2, correct XOR DUT -> Pass=1, Error_Count=0; same DUT with GATE_OP=0 -> Fail_Vector=1110, Error_Count=3.

Source files
------------

// File: rtl/gate_tt_pkg.sv
// rtl/gate_tt_pkg.sv - shared FSM state type, gate op codes and stimulus vector table
package gate_tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  // Entry n holds {A,B} for vector index n: 00, 10, 01, 11
  localparam logic [3:0][1:0] VEC_TABLE = '{2'b11, 2'b01, 2'b10, 2'b00};

endpackage

// File: rtl/gate_ref.sv
// rtl/gate_ref.sv - combinational expected output of the selected two-input gate
module gate_ref
  import gate_tt_pkg::*;
(
  input  logic       A,
  input  logic       B,
  input  logic [1:0] op,
  output logic       expected
);

  always_comb begin
    expected = 1'b0;
    case (op)
      OP_AND:  expected = A & B;
      OP_OR:   expected = A | B;
      OP_XOR:  expected = A ^ B;
      OP_NAND: expected = ~(A & B);
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_tt_checker.sv
// rtl/gate_tt_checker.sv - truth-table checker for a 2-input gate; GATE_TT_ABORT_EN adds an Abort input
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int GATE_OP       = 0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic       Gate_Output,
`ifdef GATE_TT_ABORT_EN
  input  logic       Abort,
`endif
  output logic       Input_A,
  output logic       Input_B,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [2:0] Error_Count,
  output logic [3:0] Fail_Vector
);

  localparam logic [1:0] OP_SEL      = 2'(GATE_OP);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic       expected;
  logic       abort_req;

`ifdef GATE_TT_ABORT_EN
  assign abort_req = Abort;
`else
  assign abort_req = 1'b0;
`endif

  // Expected value is derived from the registered inputs actually applied to the gate
  gate_ref u_ref (
    .A        (Input_A),
    .B        (Input_B),
    .op       (OP_SEL),
    .expected (expected)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      idx         <= 2'd0;
      cnt         <= 8'd0;
      Input_A     <= 1'b0;
      Input_B     <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Pass        <= 1'b0;
      Error_Count <= 3'd0;
      Fail_Vector <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          Done    <= 1'b0;
          Input_A <= 1'b0;
          Input_B <= 1'b0;
          if (Start) begin
            state              <= ST_SETTLE;
            idx                <= 2'd0;
            cnt                <= SETTLE_LOAD;
            {Input_A, Input_B} <= VEC_TABLE[0];
            Busy               <= 1'b1;
            Pass               <= 1'b0;
            Error_Count        <= 3'd0;
            Fail_Vector        <= 4'd0;
          end
        end
        ST_SETTLE: begin
          if (abort_req) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            Input_A     <= 1'b0;
            Input_B     <= 1'b0;
            Busy        <= 1'b0;
            Error_Count <= 3'd0;
            Fail_Vector <= 4'd0;
          end else if (cnt == 8'd0) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_SAMPLE: begin
          if (abort_req) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            Input_A     <= 1'b0;
            Input_B     <= 1'b0;
            Busy        <= 1'b0;
            Error_Count <= 3'd0;
            Fail_Vector <= 4'd0;
          end else begin
            if (Gate_Output != expected) begin
              Error_Count      <= Error_Count + 3'd1;
              Fail_Vector[idx] <= 1'b1;
            end
            if (idx == 2'd3) begin
              state   <= ST_DONE;
              Busy    <= 1'b0;
              Input_A <= 1'b0;
              Input_B <= 1'b0;
            end else begin
              state              <= ST_SETTLE;
              idx                <= idx + 2'd1;
              cnt                <= SETTLE_LOAD;
              {Input_A, Input_B} <= VEC_TABLE[idx + 2'd1];
            end
          end
        end
        ST_DONE: begin
          // Start is not sampled here, so a held Start waits for the following IDLE cycle
          state <= ST_IDLE;
          idx   <= 2'd0;
          Done  <= 1'b1;
          Pass  <= (Error_Count == 3'd0);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb/tb_gate_tt_checker.sv - randomized self-checking bench for gate_tt_checker
module tb_gate_tt_checker;

  localparam int S0  = 4;
  localparam int OP0 = 0;
  localparam int S1  = 1;
  localparam int OP1 = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start [2];
  logic       gout  [2];
  logic       ia    [2];
  logic       ib    [2];
  logic       busy  [2];
  logic       done  [2];
  logic       pass  [2];
  logic [2:0] ec    [2];
  logic [3:0] fv    [2];
`ifdef GATE_TT_ABORT_EN
  logic       abort [2];
`endif

  int         gfn   [2];
  logic [3:0] fmask [2];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  // 0 AND, 1 OR, 2 XOR, 3 NAND, 4 stuck at one
  function automatic logic truth(input int f, input logic a, input logic b);
    case (f)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a & b);
      default: return 1'b1;
    endcase
  endfunction

  // Simulated gate under test: chosen function with a per-vector fault mask, vector = {b,a}
  assign gout[0] = truth(gfn[0], ia[0], ib[0]) ^ fmask[0][{ib[0], ia[0]}];
  assign gout[1] = truth(gfn[1], ia[1], ib[1]) ^ fmask[1][{ib[1], ia[1]}];

  function automatic logic [3:0] exp_fv(input int op, input int f, input logic [3:0] m);
    logic [3:0] r;
    logic a, b;
    r = 4'd0;
    for (int v = 0; v < 4; v++) begin
      a = (v % 2) == 1;
      b = v >= 2;
      r[v] = (truth(f, a, b) ^ m[v]) != truth(op, a, b);
    end
    return r;
  endfunction

  function automatic int popcount4(input logic [3:0] x);
    int n;
    n = 0;
    for (int k = 0; k < 4; k++) n += int'(x[k]);
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input int i, input string tag);
    check({tag, "_busy"}, 32'(busy[i]), 32'd0);
    check({tag, "_a"},    32'(ia[i]),   32'd0);
    check({tag, "_b"},    32'(ib[i]),   32'd0);
    check({tag, "_done"}, 32'(done[i]), 32'd0);
  endtask

  // One complete run with cycle-exact checks; called away from clock edges
  task automatic run_one(input int i, input int s, input int op, input int f, input logic [3:0] m);
    logic [3:0] efv;
    int last, v;
    gfn[i]   = f;
    fmask[i] = m;
    efv      = exp_fv(op, f, m);
    last     = 4 * (s + 1);
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    for (int e = 0; e <= last + 2; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      if (e < last) begin
        v = e / (s + 1);
        check("run_busy", 32'(busy[i]), 32'd1);
        check("run_a",    32'(ia[i]),   32'((v % 2) == 1));
        check("run_b",    32'(ib[i]),   32'(v >= 2));
        check("run_done", 32'(done[i]), 32'd0);
        if (e == 0) begin
          check("accept_ec",   32'(ec[i]),   32'd0);
          check("accept_fv",   32'(fv[i]),   32'd0);
          check("accept_pass", 32'(pass[i]), 32'd0);
        end
      end else if (e == last) begin
        check_idle_outputs(i, "donestate");
      end else if (e == last + 1) begin
        check("done_pulse", 32'(done[i]), 32'd1);
        check("done_busy",  32'(busy[i]), 32'd0);
        check("pass",       32'(pass[i]), 32'(efv == 4'd0));
        check("err_count",  32'(ec[i]),   32'(popcount4(efv)));
        check("fail_vec",   32'(fv[i]),   32'(efv));
      end else begin
        check("done_width", 32'(done[i]), 32'd0);
        check("hold_pass",  32'(pass[i]), 32'(efv == 4'd0));
        check("hold_ec",    32'(ec[i]),   32'(popcount4(efv)));
        check("hold_fv",    32'(fv[i]),   32'(efv));
      end
    end
  endtask

  gate_tt_checker #(.SETTLE_CYCLES(S0), .GATE_OP(OP0)) u0 (
    .Clk(clk), .Reset_n(rst_n), .Start(start[0]), .Gate_Output(gout[0]),
`ifdef GATE_TT_ABORT_EN
    .Abort(abort[0]),
`endif
    .Input_A(ia[0]), .Input_B(ib[0]), .Busy(busy[0]), .Done(done[0]),
    .Pass(pass[0]), .Error_Count(ec[0]), .Fail_Vector(fv[0])
  );

  gate_tt_checker #(.SETTLE_CYCLES(S1), .GATE_OP(OP1)) u1 (
    .Clk(clk), .Reset_n(rst_n), .Start(start[1]), .Gate_Output(gout[1]),
`ifdef GATE_TT_ABORT_EN
    .Abort(abort[1]),
`endif
    .Input_A(ia[1]), .Input_B(ib[1]), .Busy(busy[1]), .Done(done[1]),
    .Pass(pass[1]), .Error_Count(ec[1]), .Fail_Vector(fv[1])
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, f, seen;
    logic [3:0] m;
    start[0] = 1'b0; start[1] = 1'b0;
    gfn[0] = 0; gfn[1] = 2;
    fmask[0] = 4'd0; fmask[1] = 4'd0;
`ifdef GATE_TT_ABORT_EN
    abort[0] = 1'b0; abort[1] = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_idle_outputs(k, "reset");
      check("reset_pass", 32'(pass[k]), 32'd0);
      check("reset_ec",   32'(ec[k]),   32'd0);
      check("reset_fv",   32'(fv[k]),   32'd0);
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check_idle_outputs(0, "post_reset_idle");
    end

    run_one(0, S0, OP0, 0, 4'b0000);
    run_one(0, S0, OP0, 4, 4'b0000);
    repeat (6) begin
      @(posedge clk); #1;
      check("held_ec",   32'(ec[0]),   32'd3);
      check("held_fv",   32'(fv[0]),   32'b0111);
      check("held_pass", 32'(pass[0]), 32'd0);
      check_idle_outputs(0, "held_idle");
    end
    run_one(1, S1, OP1, 2, 4'b0000);
    run_one(0, S0, OP0, 2, 4'b0000);

    for (int r = 0; r < 8; r++) begin
      i = int'($urandom_range(0, 1));
      f = int'($urandom_range(0, 4));
      m = 4'($urandom);
      if (i == 0) run_one(0, S0, OP0, f, m);
      else        run_one(1, S1, OP1, f, m);
    end

    // Start held high: accepts every 22 edges, results cleared at each accept
    gfn[0] = 0; fmask[0] = 4'b1111;
    start[0] = 1'b1;
    @(posedge clk); #1;
    for (int e = 0; e < 50; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      check("b2b_done", 32'(done[0]), 32'((e % 22) == 21));
      check("b2b_busy", 32'(busy[0]), 32'((e % 22) < 20));
      if ((e % 22) == 0) check("b2b_clear", 32'(ec[0]), 32'd0);
    end
    start[0] = 1'b0;
    seen = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      @(posedge clk); #1;
      if (done[0]) seen = 1;
    end
    check("b2b_final_seen", 32'(seen), 32'd1);
    check("b2b_final_ec",   32'(ec[0]), 32'd4);
    check("b2b_final_fv",   32'(fv[0]), 32'b1111);
    @(posedge clk); #1;

    // Asynchronous reset during SETTLE of vector index 2
    fmask[0] = 4'b0001;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("pre_reset_a", 32'(ia[0]), 32'd0);
    check("pre_reset_b", 32'(ib[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs(0, "async_reset");
    check("async_reset_ec",   32'(ec[0]),   32'd0);
    check("async_reset_fv",   32'(fv[0]),   32'd0);
    check("async_reset_pass", 32'(pass[0]), 32'd0);
    #2;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check_idle_outputs(0, "after_reset");
    end

`ifdef GATE_TT_ABORT_EN
    gfn[0] = 4; fmask[0] = 4'b0000;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_pre_a",  32'(ia[0]), 32'd1);
    check("abort_pre_ec", 32'(ec[0]), 32'd1);
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    check_idle_outputs(0, "abort");
    check("abort_ec", 32'(ec[0]), 32'd0);
    check("abort_fv", 32'(fv[0]), 32'd0);
    repeat (25) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done[0]), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
